// File: rtl/main_fsm.sv
// Multi-cycle RISC-V style main control FSM: sequences fetch, decode, memory and
// execute steps and drives datapath selects/enables from the current state.
module main_fsm #(
    parameter int OP_WIDTH     = 7,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    Zero,
    input  logic                    mem_ready,
    output logic                    PCWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [ALU_OP_WIDTH-1:0] ALUOp,
    output logic                    RegWrite,
    output logic                    illegal_op,
    output logic [3:0]              state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT = ALU_OP_WIDTH'(2);

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    state_t state;
    state_t next_state;

    logic pc_write_c;
    logic mem_write_c;
    logic ir_write_c;
    logic reg_write_c;
    logic illegal_c;

    function automatic logic op_supported(input logic [OP_WIDTH-1:0] o);
        return (o == OP_LOAD)  || (o == OP_STORE) || (o == OP_RTYPE) ||
               (o == OP_ITYPE) || (o == OP_JAL)   || (o == OP_BRANCH);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // op is only consulted in DECODE and MEMADR; elsewhere it is a don't-care
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if ((op == OP_LOAD) || (op == OP_STORE)) begin
                    next_state = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    next_state = S_EXECR;
                end else if (op == OP_ITYPE) begin
                    next_state = S_EXECI;
                end else if (op == OP_JAL) begin
                    next_state = S_JAL;
                end else if (op == OP_BRANCH) begin
                    next_state = S_BEQ;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALU_ADD;
                ResultSrc  = RES_ALURES;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALU_ADD;
                illegal_c = !op_supported(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                ResultSrc   = RES_ALUOUT;
                mem_write_c = mem_ready;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_c = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALU_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALU_ADD;
                ResultSrc  = RES_ALUOUT;
                pc_write_c = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                pc_write_c = Zero;
            end
            default: begin
                pc_write_c = 1'b0;
            end
        endcase
    end

    // Enables are masked while reset is held so FETCH cannot write PC/IR early
    assign PCWrite    = rst_n & pc_write_c;
    assign MemWrite   = rst_n & mem_write_c;
    assign IRWrite    = rst_n & ir_write_c;
    assign RegWrite   = rst_n & reg_write_c;
    assign illegal_op = rst_n & illegal_c;
    assign state_o    = state;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed instruction table, hand-written stall/reset
// sequences, and randomized instruction streams against a path-based model.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_o;

    main_fsm #(.OP_WIDTH(7), .ALU_OP_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .Zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    int checks = 0;
    int errors = 0;

    // Enable sources: 0 = low, 1 = high, 2 = follows mem_ready, 3 = follows Zero
    typedef struct {
        int pcw; int irw; int memw; int adr; int rs; int sa; int sb; int alu; int rw;
    } ctl_t;
    ctl_t ctl_tab[11];

    typedef struct {
        logic [6:0] op; logic z; int n; int seq[6]; int n_rw; int n_pcw; int n_ill;
    } vec_t;
    vec_t vt[9];

    int path[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int src(input int code, input logic mr, input logic z);
        case (code)
            1: return 1;
            2: return int'(mr);
            3: return int'(z);
            default: return 0;
        endcase
    endfunction

    function automatic bit supported(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, JL, BQ};
    endfunction

    task automatic check_outputs(input int s, input bit in_rst);
        ctl_t c;
        c = ctl_tab[s];
        check("state", 32'(state_o), s);
        check($sformatf("PCWrite@s%0d", s), 32'(PCWrite), in_rst ? 0 : src(c.pcw, mem_ready, zero));
        check($sformatf("IRWrite@s%0d", s), 32'(IRWrite), in_rst ? 0 : src(c.irw, mem_ready, zero));
        check($sformatf("MemWrite@s%0d", s), 32'(MemWrite), in_rst ? 0 : src(c.memw, mem_ready, zero));
        check($sformatf("RegWrite@s%0d", s), 32'(RegWrite), in_rst ? 0 : c.rw);
        check($sformatf("AdrSrc@s%0d", s), 32'(AdrSrc), c.adr);
        check($sformatf("ResultSrc@s%0d", s), 32'(ResultSrc), c.rs);
        check($sformatf("ALUSrcA@s%0d", s), 32'(ALUSrcA), c.sa);
        check($sformatf("ALUSrcB@s%0d", s), 32'(ALUSrcB), c.sb);
        check($sformatf("ALUOp@s%0d", s), 32'(ALUOp), c.alu);
        check($sformatf("illegal_op@s%0d", s), 32'(illegal_op),
              (!in_rst && s == 1 && !supported(op)) ? 1 : 0);
    endtask

    task automatic step(input int s_exp, input logic mr, input logic [6:0] o, input logic z);
        @(negedge clk);
        mem_ready = mr;
        op = o;
        zero = z;
        #1;
        check_outputs(s_exp, 1'b0);
    endtask

    // Reference: an instruction is the list of states it visits; FETCH, MEMREAD
    // and MEMWRITE additionally wait for mem_ready before moving on.
    task automatic build_path(input logic [6:0] o);
        case (o)
            LW:      path = '{0, 1, 2, 3, 4};
            SW:      path = '{0, 1, 2, 5};
            RT:      path = '{0, 1, 6, 7};
            IT:      path = '{0, 1, 8, 7};
            JL:      path = '{0, 1, 9, 7};
            BQ:      path = '{0, 1, 10};
            default: path = '{0, 1};
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rw_cnt, pcw_cnt, ill_cnt, mw_cnt, idx, s, sel;
        logic mr;
        logic [6:0] ins_op, o;

        ctl_tab[0]  = '{2, 2, 0, 0, 2, 0, 2, 0, 0};
        ctl_tab[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        ctl_tab[2]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0};
        ctl_tab[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        ctl_tab[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        ctl_tab[5]  = '{0, 0, 2, 1, 0, 0, 0, 0, 0};
        ctl_tab[6]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0};
        ctl_tab[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        ctl_tab[8]  = '{0, 0, 0, 0, 0, 2, 1, 2, 0};
        ctl_tab[9]  = '{1, 0, 0, 0, 0, 1, 2, 0, 0};
        ctl_tab[10] = '{3, 0, 0, 0, 0, 2, 0, 1, 0};

        vt[0] = '{LW, 1'b0, 5, '{0, 1, 2, 3, 4, 0}, 1, 1, 0};
        vt[1] = '{SW, 1'b0, 4, '{0, 1, 2, 5, 0, 0}, 0, 1, 0};
        vt[2] = '{RT, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 1, 1, 0};
        vt[3] = '{IT, 1'b1, 4, '{0, 1, 8, 7, 0, 0}, 1, 1, 0};
        vt[4] = '{JL, 1'b0, 4, '{0, 1, 9, 7, 0, 0}, 1, 2, 0};
        vt[5] = '{BQ, 1'b1, 3, '{0, 1, 10, 0, 0, 0}, 0, 2, 0};
        vt[6] = '{BQ, 1'b0, 3, '{0, 1, 10, 0, 0, 0}, 0, 1, 0};
        vt[7] = '{7'b1111111, 1'b0, 2, '{0, 1, 0, 0, 0, 0}, 0, 1, 1};
        vt[8] = '{7'b0000000, 1'b1, 2, '{0, 1, 0, 0, 0, 0}, 0, 1, 1};

        // Power-on reset with mem_ready high: enables stay masked
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_outputs(0, 1'b1);

        // Release, then FETCH must wait for mem_ready
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        step(0, 1'b0, 7'h7F, 1'b0);
        step(0, 1'b0, 7'h7F, 1'b0);
        step(0, 1'b1, 7'h7F, 1'b0);
        step(1, 1'b1, 7'h7F, 1'b0);
        step(0, 1'b0, 7'h7F, 1'b0);

        // Directed instruction table, mem_ready held high
        for (int i = 0; i < 9; i++) begin
            rw_cnt = 0; pcw_cnt = 0; ill_cnt = 0;
            for (int c = 0; c < vt[i].n; c++) begin
                step(vt[i].seq[c], 1'b1, vt[i].op, vt[i].z);
                rw_cnt  += int'(RegWrite);
                pcw_cnt += int'(PCWrite);
                ill_cnt += int'(illegal_op);
            end
            check($sformatf("vec%0d RegWrite cycles", i), rw_cnt, vt[i].n_rw);
            check($sformatf("vec%0d PCWrite cycles", i), pcw_cnt, vt[i].n_pcw);
            check($sformatf("vec%0d illegal cycles", i), ill_cnt, vt[i].n_ill);
        end

        // Store with three stalled MEMWRITE cycles
        mw_cnt = 0;
        step(0, 1'b1, SW, 1'b0);
        step(1, 1'b1, SW, 1'b0);
        step(2, 1'b1, SW, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(5, 1'b0, 7'($urandom), 1'b0);
            mw_cnt += int'(MemWrite);
        end
        step(5, 1'b1, 7'($urandom), 1'b0);
        mw_cnt += int'(MemWrite);
        check("sw MemWrite cycles", mw_cnt, 1);
        step(0, 1'b0, 7'd0, 1'b0);

        // Asynchronous reset in the middle of MEMREAD
        step(0, 1'b1, LW, 1'b0);
        step(1, 1'b1, LW, 1'b0);
        step(2, 1'b1, LW, 1'b0);
        step(3, 1'b0, LW, 1'b0);
        #1;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1 check_outputs(0, 1'b1);
        @(negedge clk);
        #1 check_outputs(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_outputs(0, 1'b0);
        step(1, 1'b1, RT, 1'b0);
        step(6, 1'b1, 7'($urandom), 1'b0);
        step(7, 1'b1, 7'($urandom), 1'b0);

        // Random instruction stream against the path model
        idx = 0;
        path.delete();
        ins_op = 7'd0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (idx >= path.size()) begin
                sel = int'($urandom_range(0, 6));
                case (sel)
                    0: ins_op = LW;
                    1: ins_op = SW;
                    2: ins_op = RT;
                    3: ins_op = IT;
                    4: ins_op = JL;
                    5: ins_op = BQ;
                    default: ins_op = 7'($urandom);
                endcase
                build_path(ins_op);
                idx = 0;
            end
            s = path[idx];
            mr = ($urandom_range(0, 3) != 0);
            o = (s == 1 || s == 2) ? ins_op : 7'($urandom);
            step(s, mr, o, 1'($urandom));
            if (!((s == 0 || s == 3 || s == 5) && !mr)) idx++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
